serial_adder: RTL and testbench

//  Bit-serial N-bit adder: accepts two operands, adds them LSB-first one bit per clock

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_bit_full_adder.sv | 27 ++
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

  // Bit-counter width able to hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_bit_full_adder.sv
// One-bit full adder built from two half_adder cells plus an OR of their carries.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, one bit per clock.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting A-B.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic         sub
`endif
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sa_state_t     state;
  sa_state_t     state_next;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  sum_sr;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_cout;
  logic          accept;
  logic          handoff;
  logic          sub_op;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  bit_full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state decode and handshake strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handoff    = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        if (result_valid && result_ready) begin
          handoff    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs; sum/cout load on the first DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      sum_sr       <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      sum          <= '0;
      cout         <= 1'b0;
    end else begin
      state       <= state_next;
      start_ready <= (state_next == IDLE);
      if (accept) begin
        a_sr  <= a;
        b_sr  <= sub_op ? ~b : b;
        carry <= sub_op;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= (sum_sr >> 1) | (N'(fa_s) << (N - 1));
        carry  <= fa_cout;
        cnt    <= cnt + CW'(1);
      end
      if (handoff) begin
        result_valid <= 1'b0;
      end else if (state == DONE && !result_valid) begin
        result_valid <= 1'b1;
        sum          <= sum_sr;
        cout         <= carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: N=4 and N=1 instances, hand-computed expectations.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sv4, sr4, rv4, rr4, co4, sub4;
  logic [3:0] a4, b4, sum4;
  logic       sv1, sr1, rv1, rr1, co1, sub1;
  logic [0:0] a1, b1, sum1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  serial_adder #(.N(4)) u_dut4 (
    .clk(clk), .reset(rst), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .result_valid(rv4), .result_ready(rr4),
    .sum(sum4), .cout(co4)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub4)
`endif
  );

  serial_adder #(.N(1)) u_dut1 (
    .clk(clk), .reset(rst), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .result_valid(rv1), .result_ready(rr1),
    .sum(sum1), .cout(co1)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic subv);
    a4 = av; b4 = bv; sub4 = subv; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
  endtask

  task automatic wait_valid4(input string tag, input int exp_lat);
    int lat = 0;
    while (!rv4 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  // Full transaction on the N=4 instance with result_ready held high.
  task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                     input logic subv, input logic [3:0] es, input logic ec);
    rr4 = 1'b1;
    start4(av, bv, subv);
    check({tag, "_busy"}, 32'(sr4), 32'd0);
    wait_valid4(tag, 5);
    check({tag, "_sum"}, 32'(sum4), 32'(es));
    check({tag, "_cout"}, 32'(co4), 32'(ec));
    tick();
    check({tag, "_rdy"}, 32'(sr4), 32'd1);
    check({tag, "_vld"}, 32'(rv4), 32'd0);
  endtask

  initial begin
    int lat;
    logic [3:0] ra, rb;
    logic [4:0] tot;
    rst = 1'b1;
    sv4 = 1'b0; rr4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
    sv1 = 1'b0; rr1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_rdy", 32'(sr4), 32'd1);
    check("rst_vld", 32'(rv4), 32'd0);
    check("rst_sum", 32'(sum4), 32'd0);
    check("rst_cout", 32'(co4), 32'd0);
    check("rst_rdy1", 32'(sr1), 32'd1);

    // Basic add
    op4("add_5_3", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0);

    // Hold with result_ready low; start pulses must be ignored
    rr4 = 1'b0;
    start4(4'd15, 4'd1, 1'b0);
    wait_valid4("hold", 5);
    for (int i = 0; i < 10; i++) begin
      a4 = 4'd1; b4 = 4'd1; sv4 = (i % 2 == 0);
      tick();
      check("hold_sum", 32'(sum4), 32'd0);
      check("hold_cout", 32'(co4), 32'd1);
      check("hold_vld", 32'(rv4), 32'd1);
      check("hold_rdy", 32'(sr4), 32'd0);
    end
    sv4 = 1'b1; rr4 = 1'b1;
    tick();
    sv4 = 1'b0;
    check("hand_vld", 32'(rv4), 32'd0);
    check("hand_rdy", 32'(sr4), 32'd1);
    tick();
    check("no_accept_on_handoff", 32'(sr4), 32'd1);
    check("idle_hold_cout", 32'(co4), 32'd1);

    op4("add_10_4", 4'd10, 4'd4, 1'b0, 4'd14, 1'b0);
    op4("add_7_9", 4'd7, 4'd9, 1'b0, 4'd0, 1'b1);

    // Reset in the middle of SHIFT
    start4(4'd9, 4'd9, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rdy", 32'(sr4), 32'd1);
    check("mid_rst_vld", 32'(rv4), 32'd0);
    check("mid_rst_sum", 32'(sum4), 32'd0);
    check("mid_rst_cout", 32'(co4), 32'd0);
    op4("add_2_2", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op4("sub_3_5", 4'd3, 4'd5, 1'b1, 4'hE, 1'b0);
    op4("sub_5_3", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1);
`endif

    // Random back-to-back adds against a+b
    for (int i = 0; i < 8; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      tot = 5'(ra) + 5'(rb);
      op4("rand", ra, rb, 1'b0, tot[3:0], tot[4]);
    end

    // N=1 instance: 1+1 then 1+0
    rr1 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    lat = 0;
    while (!rv1 && lat < 20) begin tick(); lat++; end
    check("n1_lat", 32'(lat), 32'd2);
    check("n1_sum", 32'(sum1), 32'd0);
    check("n1_cout", 32'(co1), 32'd1);
    tick();
    check("n1_rdy", 32'(sr1), 32'd1);
    a1 = 1'b1; b1 = 1'b0; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    lat = 0;
    while (!rv1 && lat < 20) begin tick(); lat++; end
    check("n1b_lat", 32'(lat), 32'd2);
    check("n1b_sum", 32'(sum1), 32'd1);
    check("n1b_cout", 32'(co1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
